// File: rtl/maze_pkg.sv
// Shared definitions for the maze renderer.
// - Game state encoding driven on maze_renderer.state.
// - Palette held as 8-bit-per-channel reference colours; scale_rgb() keeps the
//   top cw bits of each channel and packs them as {R,G,B} in the low 3*cw bits.
package maze_pkg;

    localparam logic [1:0] ST_WELCOME = 2'd0;
    localparam logic [1:0] ST_MAP     = 2'd1;
    localparam logic [1:0] ST_WIN     = 2'd2;
    localparam logic [1:0] ST_PAUSE   = 2'd3;

    localparam int unsigned REF_CW = 8;

    localparam logic [23:0] RGB_RED    = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN  = 24'h00FF00;
    localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
    localparam logic [23:0] RGB_GRAY   = 24'h808080;
    localparam logic [23:0] RGB_BLACK  = 24'h000000;
    localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;

    function automatic logic [23:0] scale_rgb(input logic [23:0] c, input int unsigned cw);
        logic [23:0] r;
        logic [23:0] g;
        logic [23:0] b;
        r = {16'd0, c[23:16]} >> (REF_CW - cw);
        g = {16'd0, c[15:8]}  >> (REF_CW - cw);
        b = {16'd0, c[7:0]}   >> (REF_CW - cw);
        return (r << (2 * cw)) | (g << cw) | b;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer: counts frame_start pulses and toggles blink_on each time
// the count reaches BLINK_FRAMES-1 (the count then wraps to 0).
// Ports:
//   vga_clk, rst_sys_n  clock, async active-low reset (blink_on resets to 1)
//   frame_start         one pulse per frame
//   blink_on            current blink phase
//   blink_nxt           phase in effect after this cycle's frame_start, so a
//                       pixel coinciding with frame_start sees the new phase
module blink_timer
    import maze_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic vga_clk,
    input  logic rst_sys_n,
    input  logic frame_start,
    output logic blink_on,
    output logic blink_nxt
);

    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt;
    logic          wrap;

    assign wrap      = (frame_cnt == FW'(BLINK_FRAMES - 1));
    assign blink_nxt = (frame_start && wrap) ? ~blink_on : blink_on;

    always_ff @(posedge vga_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            blink_on  <= blink_nxt;
        end
    end

endmodule

// File: rtl/maze_renderer.sv
// Maze renderer: maps a VGA pixel stream onto a centred num x num block maze.
// Fixed 3-cycle pipeline: bounds/offsets -> block col/row -> index + colour.
// Ports:
//   vga_clk, rst_sys_n          clock, async active-low reset
//   state                       0 welcome, 1 map, 2 win, 3 pause
//   frame_start                 latches num/x_index/y_index and steps the blink timer
//   pix_valid_i, x, y           input pixel
//   num, map, x_index, y_index  maze size, wall bitmap (row*num+col), cursor
//   pix_valid_o, pix_data       output pixel, 3 cycles after input
//   pix_x_index, pix_y_index    block col/row of the output pixel (held when invalid)
module maze_renderer
    import maze_pkg::*;
#(
    parameter int unsigned MAX_N        = 19,
    parameter int unsigned BLOCK_W      = 24,
    parameter int unsigned CW           = 4,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                   vga_clk,
    input  logic                   rst_sys_n,
    input  logic [1:0]             state,
    input  logic                   frame_start,
    input  logic                   pix_valid_i,
    input  logic [9:0]             x,
    input  logic [8:0]             y,
    input  logic [4:0]             num,
    input  logic [MAX_N*MAX_N-1:0] map,
    input  logic [4:0]             x_index,
    input  logic [4:0]             y_index,
    output logic                   pix_valid_o,
    output logic [3*CW-1:0]        pix_data,
    output logic [4:0]             pix_x_index,
    output logic [4:0]             pix_y_index
);

    localparam int unsigned PW       = 3 * CW;
    localparam int unsigned MAP_BITS = MAX_N * MAX_N;
    localparam int unsigned IW       = $clog2(MAP_BITS + 1);

    localparam logic [PW-1:0] C_RED    = PW'(scale_rgb(RGB_RED, CW));
    localparam logic [PW-1:0] C_GREEN  = PW'(scale_rgb(RGB_GREEN, CW));
    localparam logic [PW-1:0] C_YELLOW = PW'(scale_rgb(RGB_YELLOW, CW));
    localparam logic [PW-1:0] C_GRAY   = PW'(scale_rgb(RGB_GRAY, CW));
    localparam logic [PW-1:0] C_BLACK  = PW'(scale_rgb(RGB_BLACK, CW));
    localparam logic [PW-1:0] C_WHITE  = PW'(scale_rgb(RGB_WHITE, CW));

    // Frame-latched parameters; on a frame_start cycle the incoming values are
    // used directly so the coinciding pixel already sees the new frame.
    logic [4:0] num_l, cur_x, cur_y;
    logic [4:0] num_e, cur_x_e, cur_y_e;
    logic       blink_on, blink_nxt, blink_e;

    always_ff @(posedge vga_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            num_l <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (frame_start) begin
            num_l <= num;
            cur_x <= x_index;
            cur_y <= y_index;
        end
    end

    blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .vga_clk     (vga_clk),
        .rst_sys_n   (rst_sys_n),
        .frame_start (frame_start),
        .blink_on    (blink_on),
        .blink_nxt   (blink_nxt)
    );

    assign num_e   = frame_start ? num     : num_l;
    assign cur_x_e = frame_start ? x_index : cur_x;
    assign cur_y_e = frame_start ? y_index : cur_y;
    assign blink_e = blink_nxt;

    // Stage 1: geometry in 11-bit unsigned arithmetic, bounds test, offsets.
    logic [10:0] extent, begin_x, begin_y, x_ext, y_ext;
    logic        num_ok, in_map;

    assign extent  = 11'(BLOCK_W) * {6'd0, num_e};
    assign begin_x = 11'd320 - (extent >> 1);
    assign begin_y = 11'd240 - (extent >> 1);
    assign x_ext   = {1'b0, x};
    assign y_ext   = {2'b0, y};
    assign num_ok  = (num_e >= 5'd3) && (num_e <= 5'(MAX_N));
    assign in_map  = num_ok
                  && (x_ext >= begin_x) && (x_ext < begin_x + extent)
                  && (y_ext >= begin_y) && (y_ext < begin_y + extent);

    logic        v1, in1, bl1;
    logic [1:0]  st1;
    logic [10:0] dx1, dy1;
    logic [4:0]  num1, cx1, cy1;

    always_ff @(posedge vga_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            v1 <= 1'b0; in1 <= 1'b0; bl1 <= 1'b0; st1 <= '0;
            dx1 <= '0; dy1 <= '0; num1 <= '0; cx1 <= '0; cy1 <= '0;
        end else begin
            v1   <= pix_valid_i;
            in1  <= in_map;
            bl1  <= blink_e;
            st1  <= state;
            dx1  <= x_ext - begin_x;
            dy1  <= y_ext - begin_y;
            num1 <= num_e;
            cx1  <= cur_x_e;
            cy1  <= cur_y_e;
        end
    end

    // Stage 2: block column/row (zero outside the map).
    logic        v2, in2, bl2;
    logic [1:0]  st2;
    logic [4:0]  col2, row2, num2, cx2, cy2;

    always_ff @(posedge vga_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            v2 <= 1'b0; in2 <= 1'b0; bl2 <= 1'b0; st2 <= '0;
            col2 <= '0; row2 <= '0; num2 <= '0; cx2 <= '0; cy2 <= '0;
        end else begin
            v2   <= v1;
            in2  <= in1;
            bl2  <= bl1;
            st2  <= st1;
            col2 <= in1 ? 5'(dx1 / 11'(BLOCK_W)) : '0;
            row2 <= in1 ? 5'(dy1 / 11'(BLOCK_W)) : '0;
            num2 <= num1;
            cx2  <= cx1;
            cy2  <= cy1;
        end
    end

    // Stage 3: map index, colour selection.
    logic [IW-1:0] idx;
    logic          wall, blink_eff;
    logic [PW-1:0] map_col, half_col, nxt_col;

    assign idx       = IW'(row2) * IW'(num2) + IW'(col2);
    assign wall      = (idx < IW'(MAP_BITS)) ? map[idx] : 1'b0;
    assign blink_eff = bl2 && (st2 == ST_MAP);

    always_comb begin
        map_col = C_WHITE;
        if (in2) begin
            if (col2 == cx2 && row2 == cy2 && blink_eff)
                map_col = C_RED;
            else if (col2 == 5'd1 && row2 == 5'd1)
                map_col = C_GREEN;
            else if (col2 == num2 - 5'd2 && row2 == num2 - 5'd2)
                map_col = C_YELLOW;
            else if (wall)
                map_col = C_GRAY;
            else
                map_col = C_BLACK;
        end
    end

    always_comb begin
        half_col = '0;
        for (int unsigned i = 0; i < 3; i++)
            half_col[i*CW +: CW] = map_col[i*CW +: CW] >> 1;
    end

    always_comb begin
        nxt_col = '0;
        if (v2) begin
            case (st2)
                ST_WELCOME: nxt_col = C_YELLOW;
                ST_WIN:     nxt_col = C_RED;
                ST_PAUSE:   nxt_col = half_col;
                default:    nxt_col = map_col;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pix_valid_o <= 1'b0;
            pix_data    <= '0;
            pix_x_index <= '0;
            pix_y_index <= '0;
        end else begin
            pix_valid_o <= v2;
            pix_data    <= nxt_col;
            if (v2) begin
                pix_x_index <= col2;
                pix_y_index <= row2;
            end
        end
    end

endmodule

// File: tb/tb_maze_renderer.sv
module tb_maze_renderer;

    localparam int MAX_N = 19;
    localparam int BW    = 24;
    localparam int CW    = 4;
    localparam int BF    = 16;

    logic                   vga_clk = 1'b0;
    logic                   rst_sys_n = 1'b0;
    logic [1:0]             state = '0;
    logic                   frame_start = 1'b0;
    logic                   pix_valid_i = 1'b0;
    logic [9:0]             x = '0;
    logic [8:0]             y = '0;
    logic [4:0]             num = '0;
    logic [MAX_N*MAX_N-1:0] map = '0;
    logic [4:0]             x_index = '0;
    logic [4:0]             y_index = '0;
    logic                   pix_valid_o;
    logic [3*CW-1:0]        pix_data;
    logic [4:0]             pix_x_index;
    logic [4:0]             pix_y_index;

    maze_renderer #(
        .MAX_N(MAX_N), .BLOCK_W(BW), .CW(CW), .BLINK_FRAMES(BF)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_sys_n   (rst_sys_n),
        .state       (state),
        .frame_start (frame_start),
        .pix_valid_i (pix_valid_i),
        .x           (x),
        .y           (y),
        .num         (num),
        .map         (map),
        .x_index     (x_index),
        .y_index     (y_index),
        .pix_valid_o (pix_valid_o),
        .pix_data    (pix_data),
        .pix_x_index (pix_x_index),
        .pix_y_index (pix_y_index)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Settings applied at the next drive point.
    logic [1:0] s_state = 2'd1;
    logic [4:0] s_num = 5'd19, s_xi = 5'd1, s_yi = 5'd1;

    // Reference model.
    typedef struct {
        bit        v;
        bit [11:0] data;
        bit        idx_chk;
        bit [4:0]  ix;
        bit [4:0]  iy;
    } exp_t;

    exp_t q[$];
    int   m_num, m_cx, m_cy, m_cnt;
    bit   m_blink;
    bit [4:0] m_hx, m_hy;
    bit   m_hknown;

    task automatic model_reset();
        m_num = 0; m_cx = 0; m_cy = 0; m_cnt = 0; m_blink = 1;
        m_hx = 0; m_hy = 0; m_hknown = 1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.v = 0; e.data = 0; e.idx_chk = 1; e.ix = 0; e.iy = 0;
            q.push_back(e);
        end
    endtask

    task automatic model_cycle();
        exp_t e;
        int px, py, ext, bx, by, col, row;
        bit inm;
        bit [11:0] under, c;
        if (frame_start) begin
            m_num = num; m_cx = x_index; m_cy = y_index;
            if (m_cnt == BF - 1) begin m_cnt = 0; m_blink = !m_blink; end
            else m_cnt++;
        end
        px = x; py = y; col = 0; row = 0;
        ext = BW * m_num;
        bx = 320 - ext / 2;
        by = 240 - ext / 2;
        inm = (m_num >= 3) && (m_num <= MAX_N) && (px >= bx) && (px < bx + ext)
              && (py >= by) && (py < by + ext);
        if (inm) begin col = (px - bx) / BW; row = (py - by) / BW; end
        if (!inm) under = 12'hFFF;
        else if (col == 1 && row == 1) under = 12'h0F0;
        else if (col == m_num - 2 && row == m_num - 2) under = 12'hFF0;
        else if (map[row * m_num + col]) under = 12'h888;
        else under = 12'h000;
        case (state)
            2'd0: c = 12'hFF0;
            2'd2: c = 12'hF00;
            2'd3: c = (under >> 1) & 12'h777;
            default: c = (inm && col == m_cx && row == m_cy && m_blink) ? 12'hF00 : under;
        endcase
        e.v = pix_valid_i;
        e.data = pix_valid_i ? c : 12'h000;
        if (pix_valid_i) begin
            if (inm) begin
                m_hx = 5'(col); m_hy = 5'(row); m_hknown = 1;
            end else m_hknown = 0;
            e.idx_chk = inm;
        end else e.idx_chk = m_hknown;
        e.ix = m_hx; e.iy = m_hy;
        q.push_back(e);
    endtask

    task automatic step(input bit fs, input bit pv, input int px, input int py);
        exp_t e;
        @(negedge vga_clk);
        if (q.size() >= 3) begin
            e = q.pop_front();
            check("valid", 32'(pix_valid_o), 32'(e.v));
            check("data", 32'(pix_data), 32'(e.data));
            if (e.idx_chk) begin
                check("x_index", 32'(pix_x_index), 32'(e.ix));
                check("y_index", 32'(pix_y_index), 32'(e.iy));
            end
        end
        state = s_state; num = s_num; x_index = s_xi; y_index = s_yi;
        frame_start = fs; pix_valid_i = pv;
        x = 10'(px); y = 9'(py);
        model_cycle();
    endtask

    task automatic probe(input int px, input int py);
        step(0, 1, px, py);
        repeat (3) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        #2 rst_sys_n = 1'b0;
        #1;
        check("rst_valid", 32'(pix_valid_o), 0);
        check("rst_data", 32'(pix_data), 0);
        check("rst_xidx", 32'(pix_x_index), 0);
        check("rst_yidx", 32'(pix_y_index), 0);
        @(negedge vga_clk);
        frame_start = 1'b0; pix_valid_i = 1'b0;
        @(negedge vga_clk);
        rst_sys_n = 1'b1;
        model_reset();
    endtask

    initial begin
        map = '0;
        for (int i = 0; i < MAX_N * MAX_N; i++) map[i] = 1'($urandom_range(0, 1));
        map[0]  = 1'b1;
        map[21] = 1'b0;

        do_reset();
        step(0, 0, 0, 0);

        // num 19, top-left block is a wall.
        s_state = 2'd1; s_num = 5'd19; s_xi = 5'd1; s_yi = 5'd1;
        step(1, 0, 0, 0);
        probe(92, 12);
        check("d1_gray", 32'(pix_data), 32'h888);
        check("d1_col", 32'(pix_x_index), 0);
        check("d1_row", 32'(pix_y_index), 0);
        probe(91, 12);
        check("d1_left_white", 32'(pix_data), 32'hFFF);

        // Cursor on start block blinks red, then shows green after BF frames.
        probe(92 + 24 + 5, 12 + 24 + 5);
        check("d2_red", 32'(pix_data), 32'hF00);
        repeat (BF - 1) step(1, 0, 0, 0);
        probe(92 + 24 + 5, 12 + 24 + 5);
        check("d2_green", 32'(pix_data), 32'h0F0);

        // num change without frame_start keeps the old geometry.
        s_num = 5'd9;
        probe(212, 132);
        check("d3_old_col", 32'(pix_x_index), 5);
        check("d3_old_row", 32'(pix_y_index), 5);
        step(1, 0, 0, 0);
        probe(212, 132);
        check("d3_new_gray", 32'(pix_data), 32'h888);
        check("d3_new_col", 32'(pix_x_index), 0);
        probe(211, 132);
        check("d3_bx_white", 32'(pix_data), 32'hFFF);
        probe(427, 132);
        check("d3_last_col", 32'(pix_x_index), 8);
        probe(428, 132);
        check("d3_right_white", 32'(pix_data), 32'hFFF);

        // Frame_start coincident with a pixel uses the new values.
        s_num = 5'd19;
        step(1, 1, 92, 12);
        repeat (3) step(0, 0, 0, 0);
        check("d3_coincide", 32'(pix_x_index), 0);

        // Out-of-range sizes.
        s_num = 5'd2;  step(1, 0, 0, 0); probe(320, 240);
        check("d4_num2", 32'(pix_data), 32'hFFF);
        s_num = 5'd25; step(1, 0, 0, 0); probe(320, 240);
        check("d4_num25", 32'(pix_data), 32'hFFF);

        // Other states.
        s_num = 5'd9; step(1, 0, 0, 0);
        s_state = 2'd3; probe(212 + 72 + 1, 132 + 48 + 1);
        check("d5_pause_road", 32'(pix_data), 32'h000);
        probe(0, 0);
        check("d5_pause_white", 32'(pix_data), 32'h777);
        s_state = 2'd2; probe(300, 200);
        check("d5_win", 32'(pix_data), 32'hF00);
        s_state = 2'd0; probe(300, 200);
        check("d5_welcome", 32'(pix_data), 32'hFF0);
        s_state = 2'd1;

        // Randomized stream.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) s_state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0)
                s_num = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(3, MAX_N))
                                                   : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) begin
                s_xi = 5'($urandom_range(0, 18));
                s_yi = 5'($urandom_range(0, 18));
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 639), $urandom_range(0, 479));
        end

        // Reset mid-line, then restart latency.
        s_state = 2'd1; s_num = 5'd19;
        step(1, 1, 100, 20);
        step(0, 1, 101, 20);
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 92, 12);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("d6_not_yet", 32'(pix_valid_o), 0);
        step(0, 0, 0, 0);
        check("d6_resume", 32'(pix_valid_o), 1);
        check("d6_data", 32'(pix_data), 32'h888);
        repeat (4) step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maze_renderer.md
MAZE_RENDERER -- requirements
Module: maze_renderer

Interface
REQ-001 SHALL have parameter MAX_N, default 19, meaning maximum blocks per map side.
REQ-002 SHALL have parameter BLOCK_W, default 24, meaning block edge length in pixels.
REQ-003 SHALL have parameter CW, default 4, meaning bits per colour channel; pixel width is 3*CW.
REQ-004 SHALL have parameter BLINK_FRAMES, default 16, meaning frames per cursor blink half-period.
REQ-005 SHALL have ports, clock and reset first:
  vga_clk      in   1          pixel clock; one clock; reset is asynchronous and active-low
  rst_sys_n    in   1          asynchronous active-low reset
  state        in   2          0 welcome, 1 map, 2 win, 3 pause
  frame_start  in   1          one-cycle pulse before the first pixel of a frame
  pix_valid_i  in   1          x/y carry a visible pixel
  x            in   10         pixel column
  y            in   9          pixel row
  num          in   5          blocks per side
  map          in   MAX_N*MAX_N  bit 1 = wall, bit 0 = road; index = row*num + col
  x_index      in   5          cursor column
  y_index      in   5          cursor row
  pix_valid_o  out  1          pix_valid_i delayed 3 cycles
  pix_data     out  3*CW       RGB pixel
  pix_x_index  out  5          block column of the output pixel (debug)
  pix_y_index  out  5          block row of the output pixel (debug)

Function
REQ-006 SHALL have a fixed 3-cycle latency; output at cycle t+3 SHALL correspond exactly to x/y/pix_valid_i at cycle t.
REQ-007 Stage 1 SHALL perform the in-map bounds test and compute offsets dx = x - begin_x and dy = y - begin_y.
REQ-008 Stage 2 SHALL compute col = dx / BLOCK_W and row = dy / BLOCK_W.
REQ-009 Stage 3 SHALL compute idx = row*num_l + col, select the colour and register it.
REQ-010 Colour and index SHALL derive from the same pixel; no stage-skew between index and colour.
REQ-011 num, x_index and y_index SHALL be latched into num_l and cur_x/cur_y only on frame_start, so a frame never tears.
REQ-012 begin_x SHALL be 320 - (BLOCK_W*num_l)/2 and begin_y SHALL be 240 - (BLOCK_W*num_l)/2.
REQ-013 begin_x, begin_y and the map extent SHALL be computed in 11-bit unsigned arithmetic when num_l is latched.
REQ-014 A pixel SHALL be in-map iff begin_x <= x < begin_x + BLOCK_W*num_l and begin_y <= y < begin_y + BLOCK_W*num_l.
REQ-015 If num_l < 3 or num_l > MAX_N, every pixel SHALL be treated as outside the map.
REQ-016 Colour priority in state 1 for in-map pixels SHALL be, highest first:
  - cursor (col==cur_x, row==cur_y): RED while blink_on, else the underlying colour.
  - start (1,1): GREEN.
  - end (num_l-2, num_l-2): YELLOW.
  - map[idx]==1: GRAY.
  - otherwise: BLACK.
REQ-017 Out-of-map pixels in state 1 SHALL be WHITE.
REQ-018 In state 0 every pixel SHALL be YELLOW; in state 2 RED; in state 3 in-map pixels SHALL be rendered as in state 1 with every channel halved (shift right 1), cursor not blinking.
REQ-019 Outputs for a pixel with pix_valid_i=0 SHALL give pix_data = 0, with pix_x_index/pix_y_index held.
REQ-020 blink_on SHALL toggle when a frame counter, incremented on frame_start, reaches BLINK_FRAMES-1; the counter SHALL then wrap to 0.
REQ-021 When frame_start and pix_valid_i coincide, the pixel SHALL use the newly latched values.
REQ-022 A state change SHALL take effect on the pixel sampled that cycle; state SHALL be pipelined with the pixel.

Reset
REQ-023 On rst_sys_n low the block SHALL clear, asynchronously, all pipeline registers, pix_valid_o=0, pix_data=0, pix_x_index=0, pix_y_index=0, num_l=0, the frame counter and blink_on=1.
REQ-024 Reset mid-frame SHALL flush the pipeline; the first valid output SHALL appear 3 cycles after the first post-reset pix_valid_i.

Structure
REQ-025 The colour constants (RED, GREEN, YELLOW, GRAY, BLACK, WHITE, CW-scaled) and the state encoding SHALL live in a shared package, maze_pkg.
REQ-026 The blink frame counter SHALL be the sub-module blink_timer.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
  - num=19, state=1, pixel (92,12) -> 3 cycles later col 0, row 0, GRAY if map[0]=1.
  - Cursor at (1,1), pixel inside block (1,1), blink_on=1 -> RED; after BLINK_FRAMES frame_starts -> GREEN.
  - num changes 19->9 mid-frame -> rendering keeps num 19 until the next frame_start, then begin_x=212.
  - num=2, or num=25 with MAX_N=19 -> all state-1 pixels WHITE.
  - state=3, road pixel -> 0x000; WHITE background -> 0x777; state=2 -> 0xF00.
  - rst_sys_n pulsed low mid-line -> outputs 0 immediately; valid resumes exactly 3 cycles after pix_valid_i returns.
